// File: rtl/i2c_clk_div.sv
// Integer clock divider for the I2C master state-machine clock: clk period is DIV_RATIO clk_in cycles, low phase ceil(N/2).
// Latency: first clk rise LOW clk_in cycles after reset release; no backpressure (free-running).
module i2c_clk_div #(
  parameter int DIV_RATIO = 250,
  parameter int CNT_W     = $clog2(DIV_RATIO)
) (
  input  logic clk_in,
  input  logic reset,
  output logic clk,
  output logic tick_rise,
  output logic tick_fall
);

  if (DIV_RATIO < 2) begin : g_bad_ratio
    $error("i2c_clk_div: DIV_RATIO must be >= 2");
  end

  localparam int unsigned      LOW    = (DIV_RATIO + 1) / 2;
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(DIV_RATIO - 1);
  localparam logic [CNT_W-1:0] LOW_C  = CNT_W'(LOW);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Outputs are decoded from the next count so they line up with the counter edge.
  always_comb begin
    cnt_d  = (cnt_q == LAST_C) ? '0 : cnt_q + CNT_W'(1);
    clk_d  = (cnt_d >= LOW_C);
    rise_d = (cnt_d == LOW_C);
    fall_d = (cnt_d == '0);
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign clk       = clk_q;
  assign tick_rise = rise_q;
  assign tick_fall = fall_q;

endmodule

// File: tb/tb_i2c_clk_div.sv
// Drives five dividers (N=2,4,5,8,250) from one clock/reset and checks them against an edge-count model.
module tb_i2c_clk_div;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b0;
  logic [4:0] c_o, r_o, f_o;
  int         ratios [5] = '{2, 4, 5, 8, 250};
  int         k = 0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk_in = ~clk_in;

  i2c_clk_div #(.DIV_RATIO(2))   u_n2   (.clk_in(clk_in), .reset(reset), .clk(c_o[0]), .tick_rise(r_o[0]), .tick_fall(f_o[0]));
  i2c_clk_div #(.DIV_RATIO(4))   u_n4   (.clk_in(clk_in), .reset(reset), .clk(c_o[1]), .tick_rise(r_o[1]), .tick_fall(f_o[1]));
  i2c_clk_div #(.DIV_RATIO(5))   u_n5   (.clk_in(clk_in), .reset(reset), .clk(c_o[2]), .tick_rise(r_o[2]), .tick_fall(f_o[2]));
  i2c_clk_div #(.DIV_RATIO(8))   u_n8   (.clk_in(clk_in), .reset(reset), .clk(c_o[3]), .tick_rise(r_o[3]), .tick_fall(f_o[3]));
  i2c_clk_div                    u_n250 (.clk_in(clk_in), .reset(reset), .clk(c_o[4]), .tick_rise(r_o[4]), .tick_fall(f_o[4]));

  // Reference: after the k-th counting edge since release, the phase is k mod N.
  function automatic logic exp_clk(int n, int e);
    return (e > 0) && ((e % n) >= (n + 1) / 2);
  endfunction
  function automatic logic exp_rise(int n, int e);
    return (e > 0) && ((e % n) == (n + 1) / 2);
  endfunction
  function automatic logic exp_fall(int n, int e);
    return (e > 0) && ((e % n) == 0);
  endfunction

  task automatic check(string tag, logic obs, logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%0b expected=%0b", tag, k, obs, expv);
    end
  endtask

  task automatic check_int(string tag, int obs, int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("clk_n%0d", ratios[i]),  c_o[i], exp_clk(ratios[i], k));
      check($sformatf("rise_n%0d", ratios[i]), r_o[i], exp_rise(ratios[i], k));
      check($sformatf("fall_n%0d", ratios[i]), f_o[i], exp_fall(ratios[i], k));
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    if (reset) k++;
    #1;
    check_all();
  endtask

  task automatic release_reset();
    @(negedge clk_in);
    reset = 1'b1;
  endtask

  int pat4 [7] = '{0, 1, 1, 0, 0, 1, 1};
  int hi250, rise250, fall250, hi5, rise5;
  int run_len, hold_len, dly;

  initial begin
    // Reset held low for 3 edges: everything stays cleared.
    #1;
    check_all();
    repeat (3) tick();
    release_reset();

    // N=4 directed pattern after edges 1..7, then long run for duty measurements.
    hi250 = 0; rise250 = 0; fall250 = 0; hi5 = 0; rise5 = 0;
    for (int e = 1; e <= 1000; e++) begin
      tick();
      if (e <= 7) check("pat_n4", c_o[1], pat4[e-1] != 0);
      if (e == 2 || e == 6) check("rise_n4_dir", r_o[1], 1'b1);
      if (e == 4) check("fall_n4_dir", f_o[1], 1'b1);
      if (e == 3) check("clk_n5_low_e2", c_o[2], 1'b1);
      if (e <= 50) begin
        hi5 += int'(c_o[2]);
        rise5 += int'(r_o[2]);
      end
      hi250 += int'(c_o[4]);
      rise250 += int'(r_o[4]);
      fall250 += int'(f_o[4]);
    end
    check_int("n5_high_cycles_10p", hi5, 20);
    check_int("n5_rise_count_10p", rise5, 10);
    check_int("n250_high_cycles_4p", hi250, 500);
    check_int("n250_rise_count_4p", rise250, 4);
    check_int("n250_fall_count_4p", fall250, 4);

    // N=8: async reset mid-high phase (cnt=5), between clock edges.
    @(negedge clk_in);
    reset = 1'b0;
    k = 0;
    repeat (2) tick();
    release_reset();
    repeat (5) tick();
    check("n8_high_before_reset", c_o[3], 1'b1);
    #2;
    reset = 1'b0;
    k = 0;
    #1;
    check("n8_async_drop", c_o[3], 1'b0);
    check_all();
    repeat (2) tick();
    release_reset();
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (e == 3) check("n8_low_edge3", c_o[3], 1'b0);
      if (e == 4) check("n8_rise_edge4", c_o[3], 1'b1);
    end

    // Randomised run lengths and asynchronous reset placements.
    for (int it = 0; it < 20; it++) begin
      run_len  = $urandom_range(1, 600);
      hold_len = $urandom_range(1, 4);
      dly      = $urandom_range(1, 3);
      repeat (run_len) tick();
      #(dly);
      reset = 1'b0;
      k = 0;
      #1;
      check_all();
      repeat (hold_len) tick();
      release_reset();
    end
    repeat (300) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
